// File: rtl/oled_text_feeder_if.sv
// Bus bundle between the upstream text source, the feeder and the SSD1306 driver.
// The slave modport is the feeder's view; the master modport is the view of whatever surrounds it.
interface oled_text_feeder_if #(
  parameter int DEPTH = 16,
  parameter int COLS  = 16,
  parameter int ROWS  = 8
);
  logic [7:0]               wr_data;
  logic                     wr_en;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic [7:0]               char_out;
  logic                     char_valid;
  logic                     char_ready;
  logic [$clog2(COLS)-1:0]  cursor_col;
  logic [$clog2(ROWS)-1:0]  cursor_row;
  logic                     busy;

  modport slave (
    input  wr_data, wr_en, char_ready,
    output full, empty, fifo_count, overflow,
    output char_out, char_valid, cursor_col, cursor_row, busy
  );

  modport master (
    output wr_data, wr_en, char_ready,
    input  full, empty, fifo_count, overflow,
    input  char_out, char_valid, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/oled_text_feeder.sv
// Byte FIFO plus a text-layout FSM that turns printable bytes, newline and form-feed
// into a stream of characters for an SSD1306 text driver, tracking the display cursor.
module oled_text_feeder #(
  parameter int DEPTH = 16,
  parameter int COLS  = 16,
  parameter int ROWS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  oled_text_feeder_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int PW   = $clog2(ROWS * COLS) + 1;

  localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
  localparam logic [PW-1:0]   CELLS_C  = PW'(ROWS * COLS);
  localparam logic [PW-1:0]   COLS_C   = PW'(COLS);
  localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  state_t          state_q, state_d;
  logic [7:0]      char_q, char_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   pad_q, pad_d;

  logic            full, empty, push, pop, xfer, can_pop;
  logic [7:0]      head;
  logic [CW-1:0]   col_adv;
  logic [RW-1:0]   row_adv;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = bus.wr_en && !full;
  assign xfer  = (state_q != IDLE) && bus.char_ready;

  // Cursor after this cycle's transfer; a byte popped on the same edge is laid out from here.
  always_comb begin
    col_adv = col_q;
    row_adv = row_q;
    if (xfer) begin
      if (col_q == COL_LAST) begin
        col_adv = '0;
        row_adv = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_adv = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    pad_d   = pad_q;
    col_d   = col_adv;
    row_d   = row_adv;
    can_pop = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: can_pop = 1'b1;
      SEND: begin
        if (xfer) begin
          state_d = IDLE;
          can_pop = 1'b1;
        end
      end
      PAD: begin
        if (xfer) begin
          pad_d = pad_q - PW'(1);
          if (pad_q == PW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Unknown control bytes are consumed here and simply leave the FSM where it landed.
    if (can_pop && !empty) begin
      pop = 1'b1;
      if (is_printable(head)) begin
        char_d  = head;
        state_d = SEND;
      end else if (head == 8'h0A) begin
        state_d = PAD;
        pad_d   = COLS_C - PW'(col_adv);
      end else if (head == 8'h0C) begin
        state_d = PAD;
        pad_d   = CELLS_C - (PW'(row_adv) * COLS_C + PW'(col_adv));
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = bus.wr_en && full;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      char_q     <= 8'h00;
      col_q      <= '0;
      row_q      <= '0;
      pad_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      char_q     <= char_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pad_q      <= pad_d;
    end
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.char_valid = (state_q != IDLE);
  assign bus.char_out   = (state_q == PAD) ? 8'h20 : char_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
